vga_str_gen: RTL and testbench
==============================

// Module: vga_str_gen
// PURPOSE
//   Source end of the 26-bit RGB stream bus. Free-running VGA timing generator
//   driving the stream that pixel-processing stages (splash, sprites, overlays)
//   consume. Emits a black pixel with coordinates, sync and active flags every
//   px_clk cycle.
//   Bus fields: active[0] VS[1] HS[2] YC[12:3] XC[22:13] R[23] G[24] B[25].
// PARAMETERS
//   H_ACTIVE 640  visible pixels per line
//   H_FP     16   horizontal front porch (px)
//   H_SYNC   96   horizontal sync width (px)
//   H_BP     48   horizontal back porch (px)
//   V_ACTIVE 480  visible lines per frame
//   V_FP     10   vertical front porch (lines)
//   V_SYNC   2    vertical sync width (lines)
//   V_BP     33   vertical back porch (lines)
//   HS_POL   0    asserted level of HS (0 = active-low)
//   VS_POL   0    asserted level of VS (0 = active-low)
// PORTS
//   px_clk    in   1   pixel clock; the only clock
//   rst_n     in   1   synchronous reset, active-low
//   en        in   1   count enable; low freezes timing and outputs
//   strRGB_o  out  26  RGB stream, registered
//   frame_o   out  1   one-cycle pulse aligned with the stream beat XC=0, YC=0
// BEHAVIOUR
//   - One clock, px_clk. Reset is synchronous and active-low (rst_n), sampled
//     on the px_clk rising edge.
//   - H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800).
//     V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
//     Both must be <= 1024; simulation $error at elaboration otherwise.
//   - Internal counters hc (0..H_TOTAL-1) and vc (0..V_TOTAL-1), 10 bits each.
//   - On each px_clk edge with rst_n=1 and en=1:
//     - hc increments; hc==H_TOTAL-1 wraps to 0.
//     - vc increments only on hc wrap; vc==V_TOTAL-1 wraps to 0 on that same
//       edge.
//   - Output register loads from the pre-increment counters, so latency is
//     one cycle.
//   - Field values:
//     - XC = hc, YC = vc.
//     - active = (hc<H_ACTIVE) && (vc<V_ACTIVE).
//     - HS = HS_POL when H_ACTIVE+H_FP <= hc < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL.
//     - VS = VS_POL when V_ACTIVE+V_FP <= vc < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
//       VS changes only at the hc=0 beat, i.e. on whole lines.
//     - R=G=B=0 always; downstream stages paint.
//     - frame_o = (hc==0 && vc==0), registered with the same latency.
//   - Reset (rst_n=0 at an edge):
//     - hc=vc=0.
//     - strRGB_o: active=0, XC=0, YC=0, R=G=B=0, HS=~HS_POL, VS=~VS_POL.
//     - frame_o=0.
//   - First edge after rst_n rises (en=1): strRGB_o shows XC=0, YC=0,
//     active=1, frame_o=1.
//   - Reset mid-frame: same values on the next edge. No partial-line
//     completion; the frame restarts at (0,0).
//   - en=0: counters and all outputs hold their values, frame_o included; a
//     pulse is stretched while en stays low.
//   - rst_n=0 overrides en.
//   - No handshake: downstream stages must accept one beat per cycle.
// TESTING
//   1. Reset 5 cycles, release, en=1 -> first beat XC=0 YC=0 active=1
//      frame_o=1 HS=1 VS=1 RGB=0.
//   2. Run one line -> XC 0..799 then 0; active high exactly 640 beats;
//      HS=0 exactly on XC 656..751 (96 beats).
//   3. Run one frame -> YC increments on XC wrap; VS=0 exactly for YC 490..491
//      (1600 beats); active=0 for YC>=480.
//   4. Frame wrap -> beat XC=799 YC=524 followed by XC=0 YC=0 with frame_o=1;
//      frame_o period 420000 cycles.
//   5. rst_n=0 for 1 cycle at XC=300 YC=200 -> next beat is the reset value,
//      then XC=0 YC=0 frame_o=1.
//   6. en=0 for 10 cycles at XC=655 -> strRGB_o frozen at XC=655; after en=1
//      the next beat is XC=656 with HS=0.

Source files
------------

// File: rtl/vga_str_gen.sv
// vga_str_gen: free-running VGA timing generator, source end of the 26-bit RGB
// stream bus. Emits one black pixel per px_clk cycle carrying its coordinates,
// sync levels and active flag; downstream stages paint over it.
//
// Bus layout: active[0] VS[1] HS[2] YC[12:3] XC[22:13] R[23] G[24] B[25].
//
// Ports:
//   px_clk    pixel clock, the only clock
//   rst_n     synchronous reset, active-low
//   en        count enable; low freezes counters and outputs
//   strRGB_o  registered stream beat
//   frame_o   registered pulse on the beat with XC=0, YC=0
module vga_str_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          HS_POL   = 1'b0,
    parameter bit          VS_POL   = 1'b0
) (
    input  logic        px_clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [25:0] strRGB_o,
    output logic        frame_o
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if (H_TOTAL > 1024) begin : g_h_total_chk
        $error("vga_str_gen: H_TOTAL exceeds 1024");
    end
    if (V_TOTAL > 1024) begin : g_v_total_chk
        $error("vga_str_gen: V_TOTAL exceeds 1024");
    end

    // 11-bit thresholds so a boundary equal to 1024 still compares correctly.
    localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT_E  = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_S = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_E = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT_E  = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_S = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_E = 11'(V_ACTIVE + V_FP + V_SYNC);

    localparam logic [25:0] RESET_WORD = {3'b000, 10'd0, 10'd0, ~HS_POL, ~VS_POL, 1'b0};

    logic [9:0]  hc_q, hc_d;
    logic [9:0]  vc_q, vc_d;
    logic [25:0] str_q, str_d;
    logic        frame_q, frame_d;

    logic [10:0] hc_w, vc_w;
    logic        act, hs, vs;

    always_comb begin
        hc_w = {1'b0, hc_q};
        vc_w = {1'b0, vc_q};

        hc_d = hc_q + 10'd1;
        vc_d = vc_q;
        if (hc_w == H_LAST) begin
            hc_d = 10'd0;
            vc_d = (vc_w == V_LAST) ? 10'd0 : vc_q + 10'd1;
        end

        // Output fields decode the pre-increment counters: one cycle latency.
        act = (hc_w < H_ACT_E) && (vc_w < V_ACT_E);
        hs  = ((hc_w >= H_SYNC_S) && (hc_w < H_SYNC_E)) ? HS_POL : ~HS_POL;
        vs  = ((vc_w >= V_SYNC_S) && (vc_w < V_SYNC_E)) ? VS_POL : ~VS_POL;

        str_d   = {3'b000, hc_q, vc_q, hs, vs, act};
        frame_d = (hc_q == 10'd0) && (vc_q == 10'd0);
    end

    always_ff @(posedge px_clk) begin
        if (!rst_n) begin
            hc_q    <= 10'd0;
            vc_q    <= 10'd0;
            str_q   <= RESET_WORD;
            frame_q <= 1'b0;
        end else if (en) begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            str_q   <= str_d;
            frame_q <= frame_d;
        end
    end

    assign strRGB_o = str_q;
    assign frame_o  = frame_q;

endmodule

// File: tb/tb_vga_str_gen.sv
// Bench for vga_str_gen: one instance at standard 640x480 timing and one at a
// tiny timing (30x19, inverted HS polarity) so whole frames fit in a short run.
// Expected beats come from a pixel-index model: beat n of a frame sits at
// x = n % H_TOTAL, y = (n / H_TOTAL) % V_TOTAL.
module tb_vga_str_gen;

    // Small instance timing.
    localparam int unsigned SHA = 16, SHF = 4, SHS = 6, SHB = 4;
    localparam int unsigned SVA = 12, SVF = 2, SVS = 2, SVB = 3;
    localparam bit          SHP = 1'b1, SVP = 1'b0;

    logic        clk = 1'b0;
    logic        rst_n, en;
    logic [25:0] str_d, str_s;
    logic        frame_d, frame_s;

    always #5 clk = ~clk;

    vga_str_gen dut_d (
        .px_clk   (clk),
        .rst_n    (rst_n),
        .en       (en),
        .strRGB_o (str_d),
        .frame_o  (frame_d)
    );

    vga_str_gen #(
        .H_ACTIVE (SHA), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
        .V_ACTIVE (SVA), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB),
        .HS_POL   (SHP), .VS_POL (SVP)
    ) dut_s (
        .px_clk   (clk),
        .rst_n    (rst_n),
        .en       (en),
        .strRGB_o (str_s),
        .frame_o  (frame_s)
    );

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Model state: beat index within the frame and expected {frame, word}.
    int unsigned td, ts;
    logic [26:0] ed, es;

    function automatic logic [26:0] beat(input int unsigned t,
                                         input int unsigned ha, hf, hs, hb,
                                         input int unsigned va, vf, vs, vb,
                                         input bit hp, vp);
        int unsigned ht, vt, x, y;
        logic [26:0] w;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        x  = t % ht;
        y  = (t / ht) % vt;
        w  = '0;
        w[22:13] = x[9:0];
        w[12:3]  = y[9:0];
        w[2]     = (x >= ha + hf && x < ha + hf + hs) ? hp : ~hp;
        w[1]     = (y >= va + vf && y < va + vf + vs) ? vp : ~vp;
        w[0]     = (x < ha) && (y < va);
        w[26]    = (x == 0) && (y == 0);
        return w;
    endfunction

    function automatic logic [26:0] rst_word(input bit hp, vp);
        logic [26:0] w;
        w    = '0;
        w[2] = ~hp;
        w[1] = ~vp;
        return w;
    endfunction

    task automatic chk(input string tag, input logic [25:0] obs, input logic [25:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one clock with the given inputs, advance the model, compare #1 later.
    task automatic step(input bit r, input bit e);
        rst_n = r;
        en    = e;
        @(posedge clk);
        if (!r) begin
            td = 0;
            ts = 0;
            ed = rst_word(1'b0, 1'b0);
            es = rst_word(SHP, SVP);
        end else if (e) begin
            ed = beat(td, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0);
            td = (td + 1) % (800 * 525);
            es = beat(ts, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB, SHP, SVP);
            ts = (ts + 1) % ((SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB));
        end
        #1;
        chk("std_stream", str_d, ed[25:0]);
        chk("std_frame", {25'd0, frame_d}, {25'd0, ed[26]});
        chk("small_stream", str_s, es[25:0]);
        chk("small_frame", {25'd0, frame_s}, {25'd0, es[26]});
    endtask

    logic [25:0] w;

    initial begin
        td = 0;
        ts = 0;
        ed = '0;
        es = '0;
        rst_n = 1'b0;
        en    = 1'b0;
        #2;

        // Reset held for 5 cycles.
        for (int i = 0; i < 5; i++) step(1'b0, 1'b1);
        chk("reset_word", str_d, 26'h0000006);

        // First beat after release.
        step(1'b1, 1'b1);
        chk("first_beat", str_d, 26'h0000007);
        chk("first_frame", {25'd0, frame_d}, 26'd1);

        // Run to XC=655 on the standard instance, then freeze for 10 cycles.
        for (int i = 0; i < 2000 && ed[22:13] != 10'd655; i++) step(1'b1, 1'b1);
        w = str_d;
        chk("at_655", {16'd0, w[22:13]}, 26'd655);
        for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
        w = str_d;
        chk("frozen_655", {16'd0, w[22:13]}, 26'd655);
        step(1'b1, 1'b1);
        w = str_d;
        chk("resume_656_hs", {15'd0, w[22:13], w[2]}, {15'd0, 10'd656, 1'b0});

        // Several small frames with en held high.
        for (int i = 0; i < 2000; i++) step(1'b1, 1'b1);

        // Mid-frame reset on the small instance at XC=7 YC=5.
        for (int i = 0; i < 700 && !(es[22:13] == 10'd7 && es[12:3] == 10'd5); i++)
            step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        chk("mid_reset_small", str_s, 26'h0000002);
        chk("mid_reset_frame", {25'd0, frame_s}, 26'd0);
        step(1'b1, 1'b1);
        w = str_s;
        chk("restart_xy", {6'd0, w[22:3]}, 26'd0);
        chk("restart_frame", {25'd0, frame_s}, 26'd1);

        // Randomised enable gaps and occasional resets.
        for (int i = 0; i < 3000; i++)
            step(($urandom % 300) != 0, ($urandom % 6) != 0);

        // Reset overrides en=0.
        step(1'b0, 1'b0);
        chk("reset_over_en", str_d, 26'h0000006);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
